mem_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM latch and upstream of WB. It resolves branches and jumps, performs byte/half/word loads and stores over a req/ack data-memory port, and stalls the pipe while an access is in flight. The MEM/WB pipeline register is built in.

---
 rtl/mem_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline.
//
// Resolves branches and jumps combinationally. Performs byte, halfword and
// word loads and stores over a req/ack data-memory port. Stalls the upstream
// pipe while an access is in flight. Contains the MEM/WB pipeline register.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   alu_result_in              effective address or ALU result
//   r_data2_in                 store data
//   mux_RegDst_in              destination register index
//   add_result_in, pc_jump_in  branch / jump targets
//   zero_in, m_Branch_in, m_BranchNot_in, m_Jump_in   branch controls
//   m_MemRead_in, m_MemWrite_in                       memory controls
//   wb_RegWrite_in, wb_MemtoReg_in                    write-back controls
//   opcode_in                  opcode used for load/store sizing
//   pcsrc_out, pc_target_out   PC redirect (combinational)
//   stall_out                  hold IF..EX/MEM this cycle
//   mem_req/we/addr/wdata/be   registered data-memory request
//   mem_rdata, mem_ack         data-memory response
//   read_data_out, alu_result_out, mux_RegDst_out,
//   wb_RegWrite_out, wb_MemtoReg_out                  MEM/WB register
//   misalign_out               one-cycle misaligned-access flag
module mem_stage #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B-1:0] alu_result_in,
    input  logic [B-1:0] r_data2_in,
    input  logic [W-1:0] mux_RegDst_in,
    input  logic [B-1:0] add_result_in,
    input  logic [B-1:0] pc_jump_in,
    input  logic         zero_in,
    input  logic         m_Branch_in,
    input  logic         m_BranchNot_in,
    input  logic         m_Jump_in,
    input  logic         m_MemRead_in,
    input  logic         m_MemWrite_in,
    input  logic         wb_RegWrite_in,
    input  logic         wb_MemtoReg_in,
    input  logic [5:0]   opcode_in,
    output logic         pcsrc_out,
    output logic [B-1:0] pc_target_out,
    output logic         stall_out,
    output logic         mem_req,
    output logic         mem_we,
    output logic [B-1:0] mem_addr,
    output logic [B-1:0] mem_wdata,
    output logic [3:0]   mem_be,
    input  logic [B-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [B-1:0] read_data_out,
    output logic [B-1:0] alu_result_out,
    output logic [W-1:0] mux_RegDst_out,
    output logic         wb_RegWrite_out,
    output logic         wb_MemtoReg_out,
    output logic         misalign_out
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    typedef enum logic {IDLE, REQ} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t       state, state_next;
    size_t        op_size, req_size;
    logic         op_signed, op_aligned, is_mem;
    logic         req_signed;
    logic [1:0]   req_lo;
    logic [B-1:0] st_wdata;
    logic [3:0]   st_be;
    logic         stall_int, start_req, ack_done, misalign_now;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [B-1:0] load_data;

    assign is_mem = m_MemRead_in | m_MemWrite_in;

    // Branch resolution is purely combinational on the EX/MEM fields.
    assign pcsrc_out     = m_Jump_in | (m_Branch_in & zero_in) | (m_BranchNot_in & ~zero_in);
    assign pc_target_out = m_Jump_in ? pc_jump_in : add_result_in;

    // Access size and signedness from the opcode; unknown mem opcodes are words.
    always_comb begin
        op_size    = SZ_WORD;
        op_signed  = 1'b0;
        op_aligned = 1'b1;
        case (opcode_in)
            OP_LB:         begin op_size = SZ_BYTE; op_signed = 1'b1; end
            OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH:         begin op_size = SZ_HALF; op_signed = 1'b1; end
            OP_LHU, OP_SH: op_size = SZ_HALF;
            default:       op_size = SZ_WORD;
        endcase
        case (op_size)
            SZ_BYTE: op_aligned = 1'b1;
            SZ_HALF: op_aligned = ~alu_result_in[0];
            default: op_aligned = (alu_result_in[1:0] == 2'b00);
        endcase
    end

    // Store data is replicated across every lane so the byte enables alone
    // pick the bytes written.
    always_comb begin
        st_wdata = r_data2_in;
        st_be    = 4'b1111;
        case (op_size)
            SZ_BYTE: begin
                st_wdata = {4{r_data2_in[7:0]}};
                st_be    = 4'b0001 << alu_result_in[1:0];
            end
            SZ_HALF: begin
                st_wdata = {2{r_data2_in[15:0]}};
                st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Next-state and stall logic. A misaligned op never leaves IDLE.
    always_comb begin
        state_next   = state;
        stall_int    = 1'b0;
        start_req    = 1'b0;
        ack_done     = 1'b0;
        misalign_now = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    if (op_aligned) begin
                        stall_int  = 1'b1;
                        start_req  = 1'b1;
                        state_next = REQ;
                    end else begin
                        misalign_now = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_int = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stall is masked during reset so nothing upstream sees a stale hold.
    assign stall_out = stall_int & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Memory port and the lane info needed to format the returning read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            req_size   <= SZ_WORD;
            req_signed <= 1'b0;
            req_lo     <= 2'b00;
        end else if (start_req) begin
            mem_req    <= 1'b1;
            mem_we     <= m_MemWrite_in;
            mem_addr   <= {alu_result_in[B-1:2], 2'b00};
            mem_wdata  <= st_wdata;
            mem_be     <= st_be;
            req_size   <= op_size;
            req_signed <= op_signed;
            req_lo     <= alu_result_in[1:0];
        end else if (ack_done) begin
            mem_req <= 1'b0;
        end
    end

    // Lane extraction and sign/zero extension of the read word.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = req_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (req_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        case (req_size)
            SZ_BYTE: load_data = req_signed ? {{(B-8){byte_sel[7]}}, byte_sel}
                                            : {{(B-8){1'b0}}, byte_sel};
            SZ_HALF: load_data = req_signed ? {{(B-16){half_sel[15]}}, half_sel}
                                            : {{(B-16){1'b0}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // MEM/WB register. Stalls and misaligned ops insert a bubble while data
    // fields hold; read data only changes when an access completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_out   <= '0;
            alu_result_out  <= '0;
            mux_RegDst_out  <= '0;
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= 1'b0;
            misalign_out    <= 1'b0;
        end else begin
            misalign_out <= misalign_now;
            if (stall_int || misalign_now) begin
                wb_RegWrite_out <= 1'b0;
                wb_MemtoReg_out <= 1'b0;
            end else begin
                alu_result_out  <= alu_result_in;
                mux_RegDst_out  <= mux_RegDst_in;
                wb_RegWrite_out <= wb_RegWrite_in;
                wb_MemtoReg_out <= wb_MemtoReg_in;
                if (ack_done) read_data_out <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Randomized loads, stores, ALU ops and branches are compared against a
// behavioural model built from byte-lane arithmetic.
module tb_mem_stage;
    localparam int B = 32;
    localparam int W = 5;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                           OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B,
                           OP_OTHER = 6'h30;

    logic         clk = 1'b0;
    logic         reset;
    logic [B-1:0] alu_result_in, r_data2_in, add_result_in, pc_jump_in;
    logic [W-1:0] mux_RegDst_in;
    logic         zero_in, m_Branch_in, m_BranchNot_in, m_Jump_in;
    logic         m_MemRead_in, m_MemWrite_in, wb_RegWrite_in, wb_MemtoReg_in;
    logic [5:0]   opcode_in;
    logic         pcsrc_out;
    logic [B-1:0] pc_target_out;
    logic         stall_out, mem_req, mem_we;
    logic [B-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_be;
    logic         mem_ack;
    logic [B-1:0] read_data_out, alu_result_out;
    logic [W-1:0] mux_RegDst_out;
    logic         wb_RegWrite_out, wb_MemtoReg_out, misalign_out;

    mem_stage #(.B(B), .W(W)) dut (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .r_data2_in(r_data2_in),
        .mux_RegDst_in(mux_RegDst_in), .add_result_in(add_result_in),
        .pc_jump_in(pc_jump_in), .zero_in(zero_in), .m_Branch_in(m_Branch_in),
        .m_BranchNot_in(m_BranchNot_in), .m_Jump_in(m_Jump_in),
        .m_MemRead_in(m_MemRead_in), .m_MemWrite_in(m_MemWrite_in),
        .wb_RegWrite_in(wb_RegWrite_in), .wb_MemtoReg_in(wb_MemtoReg_in),
        .opcode_in(opcode_in), .pcsrc_out(pcsrc_out), .pc_target_out(pc_target_out),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .mux_RegDst_out(mux_RegDst_out),
        .wb_RegWrite_out(wb_RegWrite_out), .wb_MemtoReg_out(wb_MemtoReg_out),
        .misalign_out(misalign_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd;
    bit          rd_valid;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic        rw;
        logic        m2r;
        logic [4:0]  dst;
    } op_t;

    int          obs_stalls;
    logic        obs_req_idle, obs_ack_stall, obs_req, obs_we, obs_stable, obs_req_after;
    logic        obs_rw, obs_m2r;
    logic [31:0] obs_addr, obs_wdata, obs_rd, obs_alu;
    logic [3:0]  obs_be;
    logic [4:0]  obs_dst;

    // Reference model: access width in bytes and lane arithmetic.
    function automatic int op_bytes(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (op == OP_SB || op == OP_SH || op == OP_SW);
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [31:0] addr);
        int n = op_bytes(op);
        int lo = int'(addr % 4);
        int mask = (1 << n) - 1;
        return 4'(mask << ((lo / n) * n));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] d);
        int n = op_bytes(op);
        if (n == 1) return (d % 256) * 32'h0101_0101;
        if (n == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int n = op_bytes(op);
        int lo = int'(addr % 4);
        logic [31:0] v;
        if (n == 1) begin
            v = (rd / (32'd1 << (8 * lo))) % 256;
            if (op == OP_LB && v >= 128) v = v - 32'd256;
            return v;
        end
        if (n == 2) begin
            v = (rd / (32'd1 << (8 * lo))) % 65536;
            if (op == OP_LH && v >= 32768) v = v - 32'd65536;
            return v;
        end
        return rd;
    endfunction

    task automatic drive_nop();
        opcode_in = 6'h00; m_MemRead_in = 1'b0; m_MemWrite_in = 1'b0;
        wb_RegWrite_in = 1'b0; wb_MemtoReg_in = 1'b0;
        m_Branch_in = 1'b0; m_BranchNot_in = 1'b0; m_Jump_in = 1'b0; zero_in = 1'b0;
        alu_result_in = $urandom; r_data2_in = $urandom; mux_RegDst_in = 5'($urandom);
        add_result_in = $urandom; pc_jump_in = $urandom; mem_ack = 1'b0;
    endtask

    // Drives one memory op through IDLE, REQ waits and ack; records what the
    // DUT shows. Called at posedge+1, returns at posedge+1.
    task automatic drive_mem_op(input op_t t);
        opcode_in = t.op; alu_result_in = t.addr; r_data2_in = t.sdata;
        mux_RegDst_in = t.dst; wb_RegWrite_in = t.rw; wb_MemtoReg_in = t.m2r;
        m_MemRead_in = !is_store(t.op); m_MemWrite_in = is_store(t.op); mem_ack = 1'b0;
        #1;
        obs_stalls = stall_out ? 1 : 0;
        obs_req_idle = mem_req;
        @(posedge clk); #1;
        obs_req = mem_req; obs_we = mem_we; obs_addr = mem_addr;
        obs_wdata = mem_wdata; obs_be = mem_be; obs_stable = 1'b1;
        for (int i = 0; i < t.waits; i++) begin
            if (stall_out) obs_stalls++;
            mem_rdata = $urandom;
            @(posedge clk); #1;
            if (mem_req !== 1'b1 || mem_we !== obs_we || mem_addr !== obs_addr ||
                mem_wdata !== obs_wdata || mem_be !== obs_be) obs_stable = 1'b0;
        end
        mem_rdata = t.rdata; mem_ack = 1'b1;
        #1;
        obs_ack_stall = stall_out;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        obs_rd = read_data_out; obs_alu = alu_result_out; obs_dst = mux_RegDst_out;
        obs_rw = wb_RegWrite_out; obs_m2r = wb_MemtoReg_out; obs_req_after = mem_req;
        drive_nop();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_nop();
        mem_rdata = '0;
        #12;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (mem_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_be: got %h expected 0", mem_be); end
        checks++; if (read_data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_data: got %h expected 0", read_data_out); end
        checks++; if (alu_result_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_result: got %h expected 0", alu_result_out); end
        checks++; if (mux_RegDst_out !== 5'h0) begin errors++; $display("[TB] FAIL reset_regdst: got %h expected 0", mux_RegDst_out); end
        checks++; if (wb_RegWrite_out !== 1'b0 || wb_MemtoReg_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_ctrl: got %b%b expected 00", wb_RegWrite_out, wb_MemtoReg_out); end
        checks++; if (misalign_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign_out); end
        reset = 1'b1;
        @(posedge clk); #1;
        last_rd = 32'h0; rd_valid = 1'b1;
    endtask

    task automatic test_alu_passthrough();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a = (i == 0) ? 32'h1234 : $urandom;
            logic [4:0]  d = 5'($urandom);
            logic        rw = (i == 0) ? 1'b1 : 1'($urandom);
            logic        m2r = (i == 0) ? 1'b0 : 1'($urandom);
            drive_nop();
            alu_result_in = a; mux_RegDst_in = d; wb_RegWrite_in = rw; wb_MemtoReg_in = m2r;
            opcode_in = 6'h00;
            #1;
            checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall[%0d]: got %b expected 0", i, stall_out); end
            @(posedge clk); #1;
            checks++; if (alu_result_out !== a) begin errors++; $display("[TB] FAIL alu_result[%0d]: got %h expected %h", i, alu_result_out, a); end
            checks++; if (mux_RegDst_out !== d) begin errors++; $display("[TB] FAIL alu_regdst[%0d]: got %h expected %h", i, mux_RegDst_out, d); end
            checks++; if (wb_RegWrite_out !== rw || wb_MemtoReg_out !== m2r) begin errors++; $display("[TB] FAIL alu_wb_ctrl[%0d]: got %b%b expected %b%b", i, wb_RegWrite_out, wb_MemtoReg_out, rw, m2r); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL alu_mem_req[%0d]: got %b expected 0", i, mem_req); end
            if (rd_valid) begin
                checks++; if (read_data_out !== last_rd) begin errors++; $display("[TB] FAIL alu_read_hold[%0d]: got %h expected %h", i, read_data_out, last_rd); end
            end
        end
        drive_nop();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 10; i++) begin
            logic j, br, bn, z, exp_src;
            logic [31:0] tgt;
            drive_nop();
            j = 1'($urandom); br = 1'($urandom); bn = 1'($urandom); z = 1'($urandom);
            if (i == 0) begin j = 0; br = 0; bn = 1; z = 0; add_result_in = 32'h40; end
            if (i == 1) begin j = 1; br = 0; bn = 0; pc_jump_in = 32'h800; end
            m_Jump_in = j; m_Branch_in = br; m_BranchNot_in = bn; zero_in = z;
            if (j) begin exp_src = 1'b1; tgt = pc_jump_in; end
            else begin
                exp_src = (br && z) || (bn && !z);
                tgt = add_result_in;
            end
            #1;
            checks++; if (pcsrc_out !== exp_src) begin errors++; $display("[TB] FAIL branch_pcsrc[%0d]: got %b expected %b", i, pcsrc_out, exp_src); end
            checks++; if (pc_target_out !== tgt) begin errors++; $display("[TB] FAIL branch_target[%0d]: got %h expected %h", i, pc_target_out, tgt); end
        end
        drive_nop();
        @(posedge clk); #1;
    endtask

    task automatic test_mem_ops();
        op_t q[$];
        op_t t;
        logic [5:0] ops[9] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_OTHER};
        q.push_back('{OP_LB,  32'h103, 32'h0, 32'h80FF_FF7F, 2, 1'b1, 1'b1, 5'd3});
        q.push_back('{OP_LBU, 32'h103, 32'h0, 32'h80FF_FF7F, 2, 1'b1, 1'b1, 5'd4});
        q.push_back('{OP_SH,  32'h202, 32'hABCD_1234, 32'h0, 0, 1'b0, 1'b0, 5'd0});
        for (int i = 0; i < 16; i++) begin
            t.op = ops[$urandom_range(0, 8)];
            t.addr = $urandom;
            t.addr = t.addr - (t.addr % 32'(op_bytes(t.op)));
            t.sdata = $urandom; t.rdata = $urandom; t.waits = $urandom_range(0, 3);
            t.rw = is_store(t.op) ? 1'b0 : 1'($urandom);
            t.m2r = is_store(t.op) ? 1'b0 : 1'b1;
            t.dst = 5'($urandom);
            q.push_back(t);
        end
        foreach (q[k]) begin
            logic st = is_store(q[k].op);
            logic [31:0] exp_rd = exp_load(q[k].op, q[k].addr, q[k].rdata);
            drive_mem_op(q[k]);
            checks++; if (obs_req_idle !== 1'b0) begin errors++; $display("[TB] FAIL mem_req_idle[%0d]: got %b expected 0", k, obs_req_idle); end
            checks++; if (obs_stalls !== 1 + q[k].waits) begin errors++; $display("[TB] FAIL mem_stall_cycles[%0d]: got %0d expected %0d", k, obs_stalls, 1 + q[k].waits); end
            checks++; if (obs_ack_stall !== 1'b0) begin errors++; $display("[TB] FAIL mem_ack_stall[%0d]: got %b expected 0", k, obs_ack_stall); end
            checks++; if (obs_req !== 1'b1) begin errors++; $display("[TB] FAIL mem_req[%0d]: got %b expected 1", k, obs_req); end
            checks++; if (obs_we !== st) begin errors++; $display("[TB] FAIL mem_we[%0d]: got %b expected %b", k, obs_we, st); end
            checks++; if (obs_addr !== q[k].addr - (q[k].addr % 4)) begin errors++; $display("[TB] FAIL mem_addr[%0d]: got %h expected %h", k, obs_addr, q[k].addr - (q[k].addr % 4)); end
            checks++; if (obs_be !== exp_be(q[k].op, q[k].addr)) begin errors++; $display("[TB] FAIL mem_be[%0d]: got %b expected %b", k, obs_be, exp_be(q[k].op, q[k].addr)); end
            checks++; if (obs_stable !== 1'b1) begin errors++; $display("[TB] FAIL mem_stable[%0d]: got %b expected 1", k, obs_stable); end
            checks++; if (obs_req_after !== 1'b0) begin errors++; $display("[TB] FAIL mem_req_after_ack[%0d]: got %b expected 0", k, obs_req_after); end
            checks++; if (obs_alu !== q[k].addr || obs_dst !== q[k].dst) begin errors++; $display("[TB] FAIL mem_wb_fields[%0d]: got %h/%h expected %h/%h", k, obs_alu, obs_dst, q[k].addr, q[k].dst); end
            checks++; if (obs_rw !== q[k].rw || obs_m2r !== q[k].m2r) begin errors++; $display("[TB] FAIL mem_wb_ctrl[%0d]: got %b%b expected %b%b", k, obs_rw, obs_m2r, q[k].rw, q[k].m2r); end
            if (st) begin
                checks++; if (obs_wdata !== exp_wdata(q[k].op, q[k].sdata)) begin errors++; $display("[TB] FAIL mem_wdata[%0d]: got %h expected %h", k, obs_wdata, exp_wdata(q[k].op, q[k].sdata)); end
                rd_valid = 1'b0;
            end else begin
                checks++; if (obs_rd !== exp_rd) begin errors++; $display("[TB] FAIL load_data[%0d]: got %h expected %h", k, obs_rd, exp_rd); end
                last_rd = exp_rd; rd_valid = 1'b1;
            end
        end
    endtask

    task automatic test_misalign();
        logic [5:0]  mops[4]  = '{OP_LW, OP_LH, OP_SW, OP_SH};
        logic [31:0] maddr[4] = '{32'h06, 32'h101, 32'h202, 32'h33};
        for (int i = 0; i < 4; i++) begin
            drive_nop();
            opcode_in = mops[i]; alu_result_in = maddr[i];
            m_MemRead_in = !is_store(mops[i]); m_MemWrite_in = is_store(mops[i]);
            wb_RegWrite_in = 1'b1; wb_MemtoReg_in = 1'b1;
            #1;
            checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL misalign_stall[%0d]: got %b expected 0", i, stall_out); end
            @(posedge clk); #1;
            checks++; if (misalign_out !== 1'b1) begin errors++; $display("[TB] FAIL misalign_flag[%0d]: got %b expected 1", i, misalign_out); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL misalign_req[%0d]: got %b expected 0", i, mem_req); end
            checks++; if (wb_RegWrite_out !== 1'b0 || wb_MemtoReg_out !== 1'b0) begin errors++; $display("[TB] FAIL misalign_bubble[%0d]: got %b%b expected 00", i, wb_RegWrite_out, wb_MemtoReg_out); end
            drive_nop();
            @(posedge clk); #1;
            checks++; if (misalign_out !== 1'b0) begin errors++; $display("[TB] FAIL misalign_clear[%0d]: got %b expected 0", i, misalign_out); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] lops[5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        op_t t;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, exp_rd;
            t.op = lops[$urandom_range(0, 4)];
            t.addr = $urandom;
            t.addr = t.addr - (t.addr % 32'(op_bytes(t.op)));
            t.sdata = $urandom; t.rdata = $urandom; t.waits = $urandom_range(0, 2);
            t.rw = 1'b1; t.m2r = 1'b1; t.dst = 5'($urandom);
            exp_rd = exp_load(t.op, t.addr, t.rdata);
            drive_mem_op(t);
            checks++; if (obs_rd !== exp_rd) begin errors++; $display("[TB] FAIL b2b_load[%0d]: got %h expected %h", i, obs_rd, exp_rd); end
            last_rd = exp_rd; rd_valid = 1'b1;
            a = $urandom;
            alu_result_in = a; wb_RegWrite_in = 1'b1; wb_MemtoReg_in = 1'b0;
            #1;
            checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_alu_stall[%0d]: got %b expected 0", i, stall_out); end
            @(posedge clk); #1;
            checks++; if (alu_result_out !== a || wb_RegWrite_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_alu[%0d]: got %h/%b expected %h/1", i, alu_result_out, wb_RegWrite_out, a); end
            checks++; if (read_data_out !== last_rd) begin errors++; $display("[TB] FAIL b2b_read_hold[%0d]: got %h expected %h", i, read_data_out, last_rd); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_req[%0d]: got %b expected 0", i, mem_req); end
        end
        drive_nop();
    endtask

    task automatic test_reset_in_req();
        drive_nop();
        opcode_in = OP_LW; alu_result_in = 32'h40; m_MemRead_in = 1'b1; wb_RegWrite_in = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rreq_enter: got %b expected 1", mem_req); end
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0) begin errors++; $display("[TB] FAIL rreq_port_ctrl: got %b%b%h expected 000", mem_req, mem_we, mem_be); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rreq_port_data: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        checks++; if (read_data_out !== 32'h0 || alu_result_out !== 32'h0 || mux_RegDst_out !== 5'h0) begin errors++; $display("[TB] FAIL rreq_wb_data: got %h/%h/%h expected 0", read_data_out, alu_result_out, mux_RegDst_out); end
        checks++; if (wb_RegWrite_out !== 1'b0 || wb_MemtoReg_out !== 1'b0 || misalign_out !== 1'b0) begin errors++; $display("[TB] FAIL rreq_wb_ctrl: got %b%b%b expected 000", wb_RegWrite_out, wb_MemtoReg_out, misalign_out); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL rreq_stall: got %b expected 0", stall_out); end
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b1;
        mem_rdata = $urandom | 32'h1; mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++; if (read_data_out !== 32'h0) begin errors++; $display("[TB] FAIL late_ack_read: got %h expected 0", read_data_out); end
        checks++; if (mem_req !== 1'b0 || wb_RegWrite_out !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_ctrl: got %b%b expected 00", mem_req, wb_RegWrite_out); end
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_idle: got %b expected 0", mem_req); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting mem_stage bench");
        test_reset();
        test_alu_passthrough();
        test_branch();
        test_mem_ops();
        test_misalign();
        test_back_to_back();
        test_reset_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
